simd_batch_sched: RTL

Sequencer placed in front of simd_top_level. Accepts one command (opcode plus vector count) and drives valid_instruction, instruction and data_size for the whole batch. It streams operand vector pairs from an upstream valid/ready source into the core and tracks in-flight beats so each core result is flagged with its index. It reports done when the last result has emerged.

---
 rtl/simd_batch_sched_if.sv | 55 +++++
 rtl/simd_batch_sched.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/simd_batch_sched_if.sv
// rtl/simd_batch_sched_if.sv - command, operand, core-drive and result signals of simd_batch_sched
//
// Purpose : groups the handshake and bus signals of the batch scheduler.
//           master = command/operand source side, slave = scheduler side.
// Signals : cmd_*      command handshake (opcode + batch length)
//           opnd_*     operand pair stream (valid/ready)
//           core_*     drive of the SIMD core instruction/data inputs
//           res_*      result flag and in-batch index
//           busy, done scheduler status
//           stall_cnt  operand stall counter, present only with SIMD_SCHED_PERF_EN
interface simd_batch_sched_if #(
    parameter int DW = 128
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [5:0]    cmd_len;
    logic          opnd_valid;
    logic          opnd_ready;
    logic [DW-1:0] opnd_a;
    logic [DW-1:0] opnd_b;
    logic          core_valid_instruction;
    logic [2:0]    core_instruction;
    logic [5:0]    core_data_size;
    logic          core_valid_data;
    logic [DW-1:0] core_opa;
    logic [DW-1:0] core_opb;
    logic          res_valid;
    logic [5:0]    res_idx;
    logic          busy;
    logic          done;
`ifdef SIMD_SCHED_PERF_EN
    logic [15:0]   stall_cnt;
`endif

    modport master (
        output cmd_valid, cmd_op, cmd_len, opnd_valid, opnd_a, opnd_b,
        input  cmd_ready, opnd_ready, core_valid_instruction, core_instruction,
        input  core_data_size, core_valid_data, core_opa, core_opb,
        input  res_valid, res_idx, busy, done
`ifdef SIMD_SCHED_PERF_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, opnd_valid, opnd_a, opnd_b,
        output cmd_ready, opnd_ready, core_valid_instruction, core_instruction,
        output core_data_size, core_valid_data, core_opa, core_opb,
        output res_valid, res_idx, busy, done
`ifdef SIMD_SCHED_PERF_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/simd_batch_sched.sv
// rtl/simd_batch_sched.sv - batch sequencer driving simd_top_level for one command
//
// Purpose : accepts one command (opcode + vector count), holds the core
//           instruction for the whole batch, streams operand pairs into the
//           core, tags each core result with its batch index and pulses done
//           once the last result has left the core pipeline.
// Ports   : clk    system clock (slow SIMD core clock)
//           reset  asynchronous, active-high
//           bus    simd_batch_sched_if.slave (cmd_*, opnd_*, core_*, res_*, busy, done)
// Params  : LATENCY core pipeline depth (1..16), DW operand vector width
// Option  : SIMD_SCHED_PERF_EN adds bus.stall_cnt, count of ISSUE cycles
//           without an offered operand pair, saturating, cleared per command.
module simd_batch_sched #(
    parameter int LATENCY = 4,
    parameter int DW      = 128
) (
    input  logic                clk,
    input  logic                reset,
    simd_batch_sched_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [5:0]           len_q;
    logic [5:0]           issued;
    logic                 cmd_ready_q;
    logic                 opnd_ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 cvi_q;
    logic [2:0]           instr_q;
    logic [5:0]           size_q;
    logic                 cvd_q;
    logic [DW-1:0]        opa_q;
    logic [DW-1:0]        opb_q;
    logic [LATENCY-1:0]   res_sr;
    logic [LATENCY-1:0]   sr_next;
    logic [5:0]           res_idx_q;
    logic                 cmd_fire;
    logic                 opnd_fire;

    // The ready flags are registered copies of the state decode, so a
    // handshake can only happen in the state that owns it.
    assign cmd_fire  = bus.cmd_valid & cmd_ready_q;
    assign opnd_fire = bus.opnd_valid & opnd_ready_q;

    // Result tracker: one bit per beat travelling through the core pipeline.
    assign sr_next = (res_sr << 1) | LATENCY'(cvd_q);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire) state_nxt = (bus.cmd_len == 6'd0) ? DONE : SETUP;
            SETUP:   state_nxt = ISSUE;
            ISSUE:   if (opnd_fire && (issued == len_q - 6'd1)) state_nxt = DRAIN;
            // Leave once nothing is left in flight after this edge, so the
            // DONE cycle directly follows the last res_valid cycle.
            DRAIN:   if (sr_next == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            len_q        <= '0;
            issued       <= '0;
            cmd_ready_q  <= 1'b0;
            opnd_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cvi_q        <= 1'b0;
            instr_q      <= '0;
            size_q       <= '0;
            cvd_q        <= 1'b0;
            opa_q        <= '0;
            opb_q        <= '0;
            res_sr       <= '0;
            res_idx_q    <= '0;
        end else begin
            state        <= state_nxt;
            cmd_ready_q  <= (state_nxt == IDLE);
            opnd_ready_q <= (state_nxt == ISSUE);
            busy_q       <= (state_nxt != IDLE);
            done_q       <= (state_nxt == DONE);
            cvi_q        <= (state_nxt == SETUP) || (state_nxt == ISSUE) || (state_nxt == DRAIN);

            // An empty batch never reaches SETUP, so the core-facing
            // instruction fields keep the previous batch's values.
            if (cmd_fire) begin
                len_q  <= bus.cmd_len;
                issued <= '0;
                if (bus.cmd_len != 6'd0) begin
                    instr_q <= bus.cmd_op;
                    size_q  <= bus.cmd_len;
                end
            end

            cvd_q <= opnd_fire;
            if (opnd_fire) begin
                opa_q  <= bus.opnd_a;
                opb_q  <= bus.opnd_b;
                issued <= issued + 6'd1;
            end

            res_sr <= sr_next;
            if (state_nxt == DONE) begin
                res_idx_q <= '0;
            end else if (res_sr[LATENCY-1]) begin
                res_idx_q <= res_idx_q + 6'd1;
            end
        end
    end

`ifdef SIMD_SCHED_PERF_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (cmd_fire) begin
            stall_q <= '0;
        end else if ((state == ISSUE) && !bus.opnd_valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`endif

    assign bus.cmd_ready              = cmd_ready_q;
    assign bus.opnd_ready             = opnd_ready_q;
    assign bus.core_valid_instruction = cvi_q;
    assign bus.core_instruction       = instr_q;
    assign bus.core_data_size         = size_q;
    assign bus.core_valid_data        = cvd_q;
    assign bus.core_opa               = opa_q;
    assign bus.core_opb               = opb_q;
    assign bus.res_valid              = res_sr[LATENCY-1];
    assign bus.res_idx                = res_idx_q;
    assign bus.busy                   = busy_q;
    assign bus.done                   = done_q;
endmodule
